// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The HALT state only exists when FETCH_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    HALT  = 2'd3
`endif
  } fetch_state_t;

  // addi x0, x0, 0 -- presented whenever the output slot is empty
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Requests are always accepted in the cycle they are raised; each request is
// answered by exactly one imem_rvalid pulse some cycles later.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps a single instruction-memory request in
// flight and presents PCF/instrF/PCPlus4F to the FEC/DEC register.
// A redirect from execute has top priority and flushes both the output slot
// and any response still in flight (via the DRAIN state).
// Optional build macro FETCH_MISALIGN_TRAP_EN: a redirect to a target that is
// not word aligned raises misalignF and parks the unit in HALT until reset.
// Without the macro the low two target bits are simply cleared.
module fetch_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallF,
  input  logic                PCSrcE,
  input  logic [WIDTH-1:0]    PCTargetE,
  fetch_unit_if.master        imem,
  output logic                validF,
  output logic [WIDTH-1:0]    PCF,
  output logic [WIDTH-1:0]    instrF,
  output logic [WIDTH-1:0]    PCPlus4F
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                misalignF
`endif
);

  import fetch_pkg::*;

  localparam logic [WIDTH-1:0] INCR       = WIDTH'(PC_INCR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  fetch_state_t     state_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_inc_s;
  logic [WIDTH-1:0] target_s;
  logic             free_s;
  logic             consume_s;
  logic             issue_s;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             trap_s;
`endif

  // Slot occupancy, request decision and next-PC candidates
  always_comb begin
    // The slot can take a new instruction when it is empty or being consumed,
    // so a request is never raised without room for its response.
    free_s    = !validF || !stallF;
    consume_s = validF && !stallF;
    issue_s   = (state_r == REQ) && free_s && !PCSrcE && !rst;
    pc_inc_s  = pc_r + INCR;
    target_s  = PCTargetE & ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_s    = (state_r == HALT) || (PCSrcE && (PCTargetE[1:0] != 2'b00));
`endif
  end

  assign imem.imem_req  = issue_s;
  assign imem.imem_addr = pc_r;

  // PC, fetch state machine and the registered output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      validF   <= 1'b0;
      PCF      <= '0;
      PCPlus4F <= '0;
      instrF   <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalignF <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (trap_s) begin
        state_r   <= HALT;
        misalignF <= 1'b1;
        validF    <= 1'b0;
        instrF    <= NOP_INSTR;
      end else
`endif
      if (PCSrcE) begin
        // Redirect wins even over a stall: flush the slot and retarget.
        pc_r   <= target_s;
        validF <= 1'b0;
        instrF <= NOP_INSTR;
        case (state_r)
          // A response arriving this very cycle is dropped; otherwise the
          // outstanding one still has to be swallowed later.
          WAIT:    state_r <= imem.imem_rvalid ? REQ : DRAIN;
          default: state_r <= state_r;
        endcase
      end else if ((state_r == WAIT) && imem.imem_rvalid) begin
        validF   <= 1'b1;
        instrF   <= imem.imem_rdata;
        PCF      <= pc_r;
        PCPlus4F <= pc_inc_s;
        pc_r     <= pc_inc_s;
        state_r  <= REQ;
      end else begin
        if (consume_s) begin
          validF <= 1'b0;
          instrF <= NOP_INSTR;
        end
        case (state_r)
          REQ: begin
            if (issue_s) begin
              state_r <= WAIT;
            end
          end
          DRAIN: begin
            // Swallow the stale response, then fetch from the redirected PC.
            if (imem.imem_rvalid) begin
              state_r <= REQ;
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage feeding the FEC→DEC pipeline register: owns the PC, issues instruction-memory requests, captures responses and presents PCF/instrF/PCPlus4F with a valid flag.
- Honours the hazard unit's stall, and the execute-stage redirect (taken branch or jump), which flushes the fetch output and any in-flight response.
- Single outstanding memory request; memory latency is variable, at least 1 cycle.

Parameters:
WIDTH, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, instrF value while not valid (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stallF  in  1  hazard unit: hold fetch outputs this cycle
PCSrcE  in  1  redirect request from execute
PCTargetE  in  WIDTH  redirect target
imem_req  out  1  memory request strobe; always accepted same cycle
imem_addr  out  WIDTH  request address
imem_rvalid  in  1  response valid, one pulse per request
imem_rdata  in  WIDTH  response instruction
validF  out  1  PCF/instrF/PCPlus4F hold a real instruction
PCF  out  WIDTH  PC of presented instruction
instrF  out  WIDTH  presented instruction
PCPlus4F  out  WIDTH  PCF+4

Behaviour:
- Reset (async, rst=1): pc_q=RESET_PC, state=REQ, validF=0, PCF=0, PCPlus4F=0, instrF=NOP_INSTR; imem_req=0 while rst is high.
- Consume: the output slot is consumed on any cycle with validF=1 and stallF=0. free = !validF || !stallF.
- States: REQ, WAIT, DRAIN.
- REQ:
  - imem_req = free && !PCSrcE; imem_addr = pc_q.
  - On a request, go to WAIT; otherwise stay in REQ.
- WAIT: on imem_rvalid (with no redirect that cycle):
  - validF<=1, instrF<=rdata, PCF<=pc_q, PCPlus4F<=pc_q+4, pc_q<=pc_q+4; go to REQ.
  - Fetch latency is 1 cycle plus memory latency. With a 1-cycle memory, throughput is one instruction per 2 cycles.
- Slot consumed with no new capture: validF<=0, instrF<=NOP_INSTR.
- A request is never issued while the slot is full and stalled, so a response always has space. The stall itself never drops or duplicates an instruction.
- Redirect (PCSrcE=1) has highest priority in every state:
  - pc_q<=PCTargetE, validF<=0, instrF<=NOP_INSTR.
  - In WAIT without imem_rvalid: go to DRAIN. In WAIT with imem_rvalid in the same cycle: discard the response, go to REQ.
  - In REQ: no request is issued that cycle; stay in REQ.
  - In DRAIN: update the target; stay in DRAIN.
- DRAIN: discard the next imem_rvalid, go to REQ, fetch the latest pc_q.
- Redirect while stallF=1: the flush still wins; the outputs are invalidated.
- Arithmetic: pc_q+4 is modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.
- imem_rvalid in REQ is a protocol error; it is ignored.
- rst mid-transaction: outputs return to reset values at once. A late response after reset is ignored because the state is REQ.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN defined:
  - Adds output misalignF (1 bit, reset 0).
  - A redirect with PCTargetE[1:0]!=0 sets misalignF=1 and enters state HALT: no requests, validF=0.
  - Only rst clears HALT.
  - An aligned redirect behaves normally.
- Undefined: PCTargetE[1:0] is forced to 2'b00; there is no extra port and no HALT state.

Decomposition:
- Package fetch_pkg:
  - typedef enum fetch_state_t {REQ, WAIT, DRAIN, HALT}
  - constants NOP_INSTR and PC_INCR=4
- No sub-module needed. Next-PC selection stays inline; the output register group may optionally be a fetch_out_reg sub-module.

Test Plan:
1. Reset release, 1-cycle memory returning 0x00500093 at address 0 -> imem_addr=0 in cycle 0; validF=1, PCF=0, PCPlus4F=4, instrF=0x00500093 in cycle 2; next imem_addr=4.
2. Slot valid, stallF=1 for 5 cycles -> imem_req=0 throughout; outputs unchanged; the fetch at PC+4 issues the cycle stallF drops.
3. Redirect to 0x100 in the same cycle as imem_rvalid -> response dropped; validF=0 next cycle; next imem_addr=0x100.
4. Redirect to 0x200 in WAIT, 3-cycle memory -> DRAIN discards the late response; the first valid PCF is 0x200.
5. RESET_PC=32'hFFFF_FFFC -> PCPlus4F=0; second fetch address is 0.
6. With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalignF=1, imem_req stays 0 until rst.
